// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbitration logic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int CLKS_PER_BIT     = 87;
    localparam int ACK_TIMEOUT_DEF  = 4;
    localparam int LOCK_TIMEOUT_DEF = 1024;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(parameter int N_REQ = 4);

    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic [IW-1:0]      grant_id;
    logic               locked;

    // Producers and the transmitter.
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, locked
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, locked
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of valid, searching from start
// upward and wrapping at N-1. Works for any N, not just powers of two.
module rr_pick import uart_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] index
);

    int idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (valid[idx[IW-1:0]]) begin
                found = 1'b1;
                index = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one external UART transmitter between N_REQ byte producers using
// round-robin arbitration with packet locking.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | transmitter free: pick a requester, run the lock timer
//   ISSUE     | pulse tx_start and req_ready, update lock / rr pointer
//   WAIT_ACK  | wait for tx_busy to rise, give up after ACK_TIMEOUT
//   WAIT_DONE | wait for tx_busy to fall
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N_REQ        = 4,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = idx_w(N_REQ);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_id;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    win_idx;
    logic             pick_found;
    logic             win_found;
    logic             locked;
    logic             owner_valid;
    logic             ack_expire;
    logic [AW-1:0]    ack_cnt;
    logic [LW-1:0]    lock_cnt;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic [N_REQ-1:0] req_ready;

    // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N_REQ)) u_pick (
        .valid (bus.req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign owner_valid = bus.req_valid[grant_id];
    assign ack_expire  = (ack_cnt == ACK_LAST);

    // While a packet lock is held only its owner can win.
    always_comb begin
        win_found = pick_found;
        win_idx   = pick_idx;
        if (locked) begin
            win_found = owner_valid;
            win_idx   = grant_id;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!bus.tx_busy && win_found) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_ACK;
            WAIT_ACK:  if (bus.tx_busy || ack_expire) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Single-cycle start and accept pulses while in ISSUE.
    always_comb begin
        tx_start  = 1'b0;
        req_ready = '0;
        if (state == ISSUE) begin
            tx_start            = 1'b1;
            req_ready[grant_id] = 1'b1;
        end
    end

    // Byte capture, packet lock, round-robin pointer and lock timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_data  <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.tx_busy && win_found) begin
                        tx_data  <= bus.req_data[8*win_idx +: 8];
                        grant_id <= win_idx;
                    end
                    // Owner valid in the expiry cycle wins, so no release then.
                    if (locked && !owner_valid) begin
                        if (lock_cnt == LOCK_LAST) begin
                            locked   <= 1'b0;
                            rr_ptr   <= next_idx(grant_id);
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else begin
                        lock_cnt <= '0;
                    end
                end
                ISSUE: begin
                    lock_cnt <= '0;
                    if (bus.req_last[grant_id]) begin
                        locked <= 1'b0;
                        rr_ptr <= next_idx(grant_id);
                    end else begin
                        locked <= 1'b1;
                    end
                end
                default: lock_cnt <= '0;
            endcase
        end
    end

    // Acknowledge timer: counts WAIT_ACK cycles, cleared everywhere else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_cnt <= '0;
        end else if (state == WAIT_ACK && !ack_expire) begin
            ack_cnt <= ack_cnt + 1'b1;
        end else begin
            ack_cnt <= '0;
        end
    end

    assign bus.tx_start  = tx_start;
    assign bus.req_ready = req_ready;
    assign bus.tx_data   = tx_data;
    assign bus.grant_id  = grant_id;
    assign bus.locked    = locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a transmitter model
// and an issue monitor, with one task per scenario.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();

    uart_tx_arbiter #(.N_REQ(N), .ACK_TIMEOUT(4), .LOCK_TIMEOUT(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester queues: {last, data} per entry.
    logic [8:0] rbuf [N][16];
    int         rhead [N];
    int         rtail [N];
    logic       pop_pend [N];
    int         bad_ready = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            rhead[i]    = 0;
            rtail[i]    = 0;
            pop_pend[i] = 1'b0;
        end
    end

    // Requesters hold their byte through the req_ready cycle and advance after it.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pop_pend[i]) begin
                rhead[i]    = rhead[i] + 1;
                pop_pend[i] = 1'b0;
            end
            if (bus.req_ready[i] === 1'b1) begin
                if (bus.req_valid[i] !== 1'b1) bad_ready++;
                pop_pend[i] = 1'b1;
            end
            bus.req_valid[i] = (rhead[i] != rtail[i]);
            if (rhead[i] != rtail[i]) begin
                bus.req_last[i]       = rbuf[i][rhead[i]][8];
                bus.req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
            end else begin
                bus.req_last[i]       = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
            end
        end
    end

    // Transmitter: busy rises the cycle after tx_start and lasts busy_len cycles.
    int   busy_len  = 20;
    int   busy_cnt  = 0;
    logic no_ack    = 1'b0;
    logic start_pend = 1'b0;

    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end else if (start_pend) begin
            busy_cnt   = busy_len;
            start_pend = 1'b0;
        end
        bus.tx_busy = (busy_cnt > 0);
        if (bus.tx_start === 1'b1 && !no_ack) start_pend = 1'b1;
    end

    // Issue monitor.
    int   n_iss = 0;
    int   iss_id [64];
    int   iss_data [64];
    int   iss_cyc [64];
    int   iss_rdy [64];
    int   iss_lk [64];
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (prev_start && n_iss > 0) iss_lk[n_iss-1] = int'(bus.locked);
        prev_start = (bus.tx_start === 1'b1);
        if (bus.tx_start === 1'b1 && n_iss < 64) begin
            iss_id[n_iss]   = int'(bus.grant_id);
            iss_data[n_iss] = int'(bus.tx_data);
            iss_cyc[n_iss]  = cyc;
            iss_rdy[n_iss]  = int'(bus.req_ready);
            n_iss++;
        end
    end

    task automatic load(input int r, input logic last, input logic [7:0] d);
        rbuf[r][rtail[r]] = {last, d};
        rtail[r] = rtail[r] + 1;
    endtask

    function automatic logic queues_empty();
        for (int i = 0; i < N; i++) begin
            if (rhead[i] != rtail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_iss(input int n, input int max_cyc, input string tag);
        int k = 0;
        while (n_iss < n && k < max_cyc) begin
            @(negedge clk); #1;
            k++;
        end
        if (n_iss < n) begin
            n_vec++; n_miss++;
            $display("FAIL %s: timeout, issues seen %0d, required %0d", tag, n_iss, n);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((!queues_empty() || bus.tx_busy !== 1'b0) && k < 5000) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 5000) begin
            n_vec++; n_miss++;
            $display("FAIL %s: drain timeout", tag);
        end
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (bus.tx_start !== 1'b0) begin n_miss++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        n_vec++; if (bus.tx_data !== 8'h00) begin n_miss++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        n_vec++; if (bus.grant_id !== 2'd0) begin n_miss++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
        n_vec++; if (bus.locked !== 1'b0) begin n_miss++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_miss++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        resetn = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_single_byte();
        int base = n_iss;
        int vcyc;
        busy_len = 20;
        @(posedge clk); #1;
        load(0, 1'b1, 8'h3F);
        @(negedge clk); #1;
        vcyc = cyc;
        wait_iss(base + 1, 50, "single_issue");
        n_vec++; if (iss_cyc[base] - vcyc != 1) begin n_miss++; $display("FAIL single_latency: got %0d want 1", iss_cyc[base] - vcyc); end
        n_vec++; if (iss_id[base] != 0) begin n_miss++; $display("FAIL single_id: got %0d want 0", iss_id[base]); end
        n_vec++; if (iss_data[base] != 'h3F) begin n_miss++; $display("FAIL single_data: got %h want 3f", iss_data[base]); end
        n_vec++; if (iss_rdy[base] != 'b0001) begin n_miss++; $display("FAIL single_ready: got %b want 0001", iss_rdy[base]); end
        wait_cyc(iss_cyc[base] + 10);
        n_vec++; if (bus.tx_data !== 8'h3F || bus.tx_busy !== 1'b1) begin n_miss++; $display("FAIL single_hold: got data %h busy %b want 3f 1", bus.tx_data, bus.tx_busy); end
        wait_cyc(iss_cyc[base] + 30);
        n_vec++; if (n_iss != base + 1) begin n_miss++; $display("FAIL single_once: got %0d starts want 1", n_iss - base); end
        drain("single_drain");
    endtask

    task automatic test_round_robin();
        int base;
        int exp_id [5]   = '{0, 1, 2, 3, 0};
        int exp_data [5] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA4};
        do_reset();
        busy_len = 870;
        base = n_iss;
        @(posedge clk); #1;
        load(0, 1'b1, 8'hA0);
        load(1, 1'b1, 8'hA1);
        load(2, 1'b1, 8'hA2);
        load(3, 1'b1, 8'hA3);
        load(0, 1'b1, 8'hA4);
        wait_iss(base + 5, 6000, "rr_issue");
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (iss_id[base+k] != exp_id[k]) begin n_miss++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, iss_id[base+k], exp_id[k]); end
            n_vec++; if (iss_data[base+k] != exp_data[k]) begin n_miss++; $display("FAIL rr_data[%0d]: got %h want %h", k, iss_data[base+k], exp_data[k]); end
        end
        n_vec++; if (iss_cyc[base+1] - iss_cyc[base] != 873) begin n_miss++; $display("FAIL rr_spacing: got %0d want 873", iss_cyc[base+1] - iss_cyc[base]); end
        drain("rr_drain");
        busy_len = 10;
    endtask

    task automatic test_packet_lock();
        int base;
        int exp_id [4]   = '{2, 2, 2, 0};
        int exp_data [4] = '{'h55, 'h56, 'h57, 'hC0};
        int exp_lk [3]   = '{1, 1, 0};
        do_reset();
        busy_len = 10;
        base = n_iss;
        @(posedge clk); #1;
        load(2, 1'b0, 8'h55);
        load(2, 1'b0, 8'h56);
        load(2, 1'b1, 8'h57);
        wait_iss(base + 1, 50, "lock_first");
        load(0, 1'b1, 8'hC0);
        load(0, 1'b1, 8'hC1);
        wait_iss(base + 5, 400, "lock_issue");
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (iss_id[base+k] != exp_id[k]) begin n_miss++; $display("FAIL lock_id[%0d]: got %0d want %0d", k, iss_id[base+k], exp_id[k]); end
            n_vec++; if (iss_data[base+k] != exp_data[k]) begin n_miss++; $display("FAIL lock_data[%0d]: got %h want %h", k, iss_data[base+k], exp_data[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (iss_lk[base+k] != exp_lk[k]) begin n_miss++; $display("FAIL lock_flag[%0d]: got %0d want %0d", k, iss_lk[base+k], exp_lk[k]); end
        end
        drain("lock_drain");
    endtask

    task automatic test_lock_timeout();
        int base;
        int c0;
        do_reset();
        busy_len = 10;
        base = n_iss;
        @(posedge clk); #1;
        load(1, 1'b0, 8'h11);
        wait_iss(base + 1, 50, "lto_first");
        c0 = iss_cyc[base];
        load(3, 1'b1, 8'h33);
        wait_cyc(c0 + 27);
        n_vec++; if (bus.locked !== 1'b1) begin n_miss++; $display("FAIL lto_held: got %b want 1", bus.locked); end
        wait_cyc(c0 + 28);
        n_vec++; if (bus.locked !== 1'b0) begin n_miss++; $display("FAIL lto_release: got %b want 0", bus.locked); end
        wait_iss(base + 2, 60, "lto_next");
        n_vec++; if (iss_cyc[base+1] - c0 != 29) begin n_miss++; $display("FAIL lto_when: got %0d want 29", iss_cyc[base+1] - c0); end
        n_vec++; if (iss_id[base+1] != 3) begin n_miss++; $display("FAIL lto_id: got %0d want 3", iss_id[base+1]); end
        n_vec++; if (iss_data[base+1] != 'h33) begin n_miss++; $display("FAIL lto_data: got %h want 33", iss_data[base+1]); end
        drain("lto_drain");
    endtask

    task automatic test_ack_timeout();
        int base;
        do_reset();
        no_ack = 1'b1;
        base = n_iss;
        @(posedge clk); #1;
        load(0, 1'b1, 8'hD0);
        load(0, 1'b1, 8'hD1);
        wait_iss(base + 2, 100, "ack_issue");
        n_vec++; if (iss_cyc[base+1] - iss_cyc[base] != 7) begin n_miss++; $display("FAIL ack_spacing: got %0d want 7", iss_cyc[base+1] - iss_cyc[base]); end
        n_vec++; if (iss_id[base+1] != 0) begin n_miss++; $display("FAIL ack_id: got %0d want 0", iss_id[base+1]); end
        n_vec++; if (iss_data[base+1] != 'hD1) begin n_miss++; $display("FAIL ack_data: got %h want d1", iss_data[base+1]); end
        drain("ack_drain");
        no_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        int c0;
        do_reset();
        busy_len = 40;
        base = n_iss;
        @(posedge clk); #1;
        load(2, 1'b1, 8'hE0);
        wait_iss(base + 1, 50, "rmid_first");
        c0 = iss_cyc[base];
        wait_cyc(c0 + 10);
        resetn = 1'b0;
        load(1, 1'b1, 8'hE1);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({bus.tx_start, bus.tx_data, bus.grant_id, bus.locked, bus.req_ready} !== 16'h0000) begin
                n_miss++;
                $display("FAIL rmid_outputs[%0d]: got start %b data %h id %0d lock %b ready %b want all 0",
                         k, bus.tx_start, bus.tx_data, bus.grant_id, bus.locked, bus.req_ready);
            end
            @(negedge clk); #1;
        end
        resetn = 1'b1;
        wait_cyc(c0 + 41);
        n_vec++; if (n_iss != base + 1) begin n_miss++; $display("FAIL rmid_wait_busy: got %0d starts want 1", n_iss - base); end
        wait_iss(base + 2, 20, "rmid_next");
        n_vec++; if (iss_cyc[base+1] - c0 != 42) begin n_miss++; $display("FAIL rmid_when: got %0d want 42", iss_cyc[base+1] - c0); end
        n_vec++; if (iss_id[base+1] != 1) begin n_miss++; $display("FAIL rmid_id: got %0d want 1", iss_id[base+1]); end
        n_vec++; if (iss_data[base+1] != 'hE1) begin n_miss++; $display("FAIL rmid_data: got %h want e1", iss_data[base+1]); end
        drain("rmid_drain");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_lock_timeout();
        test_ack_timeout();
        test_reset_mid();
        n_vec++; if (bad_ready != 0) begin n_miss++; $display("FAIL ready_without_valid: got %0d want 0", bad_ready); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the SOC's single UART transmitter (TXD path, 87 clk/bit at 10 MHz) between N_REQ byte producers, e.g. CPU MMIO, a debug monitor and LED/status reporters.
- Arbitration is round-robin with packet locking, so a multi-byte message from one requester is never interleaved with another's.
- The block sequences the transmitter's start/busy handshake; the transmitter itself is external.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 4, max cycles to wait for tx_busy to rise after tx_start.
- LOCK_TIMEOUT, 1024, idle cycles after which a packet lock whose owner stopped sending is released.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  requester i has a byte on req_data[8i+:8].
- req_data  in  8*N_REQ  bytes, requester i at [8i+7:8i].
- req_last  in  N_REQ  byte i is the last of its packet.
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte to send; held stable from tx_start until tx_busy falls.
- tx_busy  in  1  transmitter busy (start bit through stop bit).
- grant_id  out  $clog2(N_REQ)  current/last granted requester.
- locked  out  1  packet lock held.

Behaviour:
- Clock, reset and polarity: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, locked=0, rr_ptr=0, timers=0. Asserting resetn low mid-byte aborts immediately; the transmitter finishes the byte on its own and the arbiter ignores tx_busy until it returns to IDLE.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE, selection: acts only when tx_busy=0.
  - Locked: only grant_id is eligible.
  - Unlocked: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - On a winner: latch tx_data=req_data[win], grant_id=win, go to ISSUE.
- IDLE, lock timeout: while locked and req_valid[grant_id]=0, the lock timer increments. When it reaches LOCK_TIMEOUT-1: locked=0, rr_ptr=grant_id+1 mod N_REQ, timer=0. The timer clears whenever the owner is valid or the lock is not held.
- ISSUE (1 cycle):
  - tx_start=1 and req_ready[grant_id]=1, both exactly one cycle.
  - If req_last[grant_id]=1: locked=0 and rr_ptr=grant_id+1 mod N_REQ. Otherwise locked=1.
  - Go to WAIT_ACK.
- WAIT_ACK: when tx_busy=1, go to WAIT_DONE. After ACK_TIMEOUT cycles without it, go to WAIT_DONE anyway (tolerates a fast or missing transmitter).
- WAIT_DONE: when tx_busy=0, go to IDLE.
- Throughput: one byte per transmitter frame plus 3 cycles of overhead (ISSUE, the first WAIT_ACK cycle, IDLE).
- Requester side: a requester must hold req_valid, req_data and req_last stable until its req_ready pulse. The arbiter never pulses req_ready for a requester whose req_valid is 0.
- rr_ptr wraps N_REQ-1 -> 0. An N_REQ that is not a power of two uses an explicit modulo compare.
- Simultaneous events: several valids in IDLE resolve by round-robin. In IDLE, the owner's req_valid rising in the same cycle the lock timer expires counts as valid: the lock is kept and that byte is issued.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef (2-bit enum: IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
  - CLKS_PER_BIT=87.
  - Default ACK_TIMEOUT and LOCK_TIMEOUT constants.
- Sub-module rr_pick: combinational round-robin priority picker with inputs valid vector and start pointer, outputs found and index. It is reused by future bus arbiters.

Test Plan:
- Single byte: req_valid[0]=1, data 8'h3F, last=1.
  - Required: tx_start pulse one cycle after valid, with tx_data=8'h3F; req_ready[0] pulses once, in the same cycle; no second tx_start until tx_busy falls.
- Round-robin: all four valid with last=1 and data 8'hA0..8'hA3, transmitter model busy for 870 cycles.
  - Required: issue order 0,1,2,3, then 0 again if still valid; rr_ptr wraps 3->0.
- Packet lock: requester 2 sends 8'h55, 8'h56, 8'h57 (last on 8'h57) while requester 0 is continuously valid.
  - Required: three consecutive grants to 2 with locked=1 between them, then a grant to 0.
- Lock timeout, LOCK_TIMEOUT=16: requester 1 sends a byte with last=0, then drops valid; requester 3 is valid.
  - Required: locked falls after 16 idle cycles and requester 3 is granted next.
- ACK timeout: transmitter model never raises tx_busy.
  - Required: the FSM returns to IDLE 4 cycles after ISSUE plus 1 cycle; the next byte issues.
- Reset mid-operation: pull resetn low during WAIT_DONE, release 3 cycles later.
  - Required: all outputs are 0 while reset is low; the FSM waits for tx_busy=0 before the next tx_start.
